// File: rtl/neosd_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : neosd_rd_seq
// Brief    : SD multi-block read sequencer; drives the DAT FSM and buffers
//            received words in a one-entry valid/ready slot.
//            Optional start-bit timeout: NEOSD_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module neosd_rd_seq #(
    parameter int BLK_W = 16,
    parameter int TMO_W = 20
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clkstrb_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [BLK_W-1:0] cfg_blocks_i,
    input  logic             cfg_d4_i,
    input  logic [TMO_W-1:0] cfg_tmo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_crc_o,
    output logic             err_tmo_o,
    output logic             err_abort_o,
    output logic [BLK_W-1:0] blk_cnt_o,
    output logic             dat_start_o,
    output logic             dat_ack_o,
    output logic             dat_last_o,
    output logic             dat_d4_o,
    output logic [1:0]       dat_dmode_o,
    input  logic             dat_idle_i,
    input  logic             dat_data_i,
    input  logic             dat_blk_done_i,
    input  logic             dat_crc_ok_i,
    input  logic [31:0]      dat_word_i,
    output logic [31:0]      rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_ACK   = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [BLK_W-1:0] c_BLK_ONE = {{(BLK_W-1){1'b0}}, 1'b1};
    localparam logic [BLK_W-1:0] c_BLK_MAX = {BLK_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [BLK_W-1:0] r_blk_tgt;
    logic [BLK_W-1:0] r_blk_cnt;
    logic [BLK_W-1:0] w_blk_inc;
    logic             r_err_crc;
    logic             r_err_abort;
    logic [31:0]      r_rx_data;
    logic             r_rx_valid;
    logic             w_capture;
    logic             w_set_abort;
    logic             w_tmo_hit;
    logic             w_start;

    assign w_start   = (r_state == S_IDLE) && start_i;
    assign w_blk_inc = (r_blk_cnt == c_BLK_MAX) ? r_blk_cnt : (r_blk_cnt + c_BLK_ONE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority in WAIT: abort, then timeout, then block-done; capture only on a quiet cycle.
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        dat_start_o = 1'b0;
        dat_ack_o   = 1'b0;
        dat_last_o  = 1'b0;
        w_capture   = 1'b0;
        w_set_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_state_nxt = S_START;
            end
            S_START: begin
                dat_start_o = 1'b1;
                if (abort_i) begin
                    w_set_abort = 1'b1;
                    w_state_nxt = S_STOP;
                end else if (!dat_idle_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_set_abort = abort_i;
                if (abort_i || w_tmo_hit ||
                    (dat_blk_done_i && (!dat_crc_ok_i || (w_blk_inc == r_blk_tgt)))) begin
                    w_state_nxt = S_STOP;
                end else if (!dat_blk_done_i && dat_data_i && !r_rx_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_CAPT;
                end
            end
            // CAPT is the first ack cycle after the load; ACK holds it until the word drops.
            S_CAPT, S_ACK: begin
                dat_ack_o   = 1'b1;
                w_set_abort = abort_i;
                if (!dat_data_i) begin
                    w_state_nxt = (abort_i || r_err_abort) ? S_STOP : S_WAIT;
                end else begin
                    w_state_nxt = S_ACK;
                end
            end
            S_STOP: begin
                dat_last_o = 1'b1;
                if (dat_idle_i) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_blk_tgt   <= '0;
            r_blk_cnt   <= '0;
            r_err_crc   <= 1'b0;
            r_err_abort <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            if (w_start) begin
                r_blk_tgt   <= (cfg_blocks_i == '0) ? c_BLK_ONE : cfg_blocks_i;
                r_blk_cnt   <= '0;
                r_err_crc   <= 1'b0;
                r_err_abort <= 1'b0;
            end else begin
                if (w_set_abort) r_err_abort <= 1'b1;
                if ((r_state == S_WAIT) && dat_blk_done_i) begin
                    if (dat_crc_ok_i) r_blk_cnt <= w_blk_inc;
                    else              r_err_crc <= 1'b1;
                end
            end
            if (w_capture) begin
                r_rx_data  <= dat_word_i;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef NEOSD_RD_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TMO_W:0]   w_tmo_next;
    logic             r_got_word;
    logic             r_err_tmo;

    assign w_tmo_next = {1'b0, r_tmo_cnt} + {{TMO_W{1'b0}}, 1'b1};
    assign w_tmo_hit  = (r_state == S_WAIT) && !r_got_word && clkstrb_i &&
                        (w_tmo_next >= {1'b0, cfg_tmo_i});

    // Only the wait for a block's first word is timed; later gaps are DAT FSM pacing.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tmo_cnt  <= '0;
            r_got_word <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else if (w_start) begin
            r_tmo_cnt  <= '0;
            r_got_word <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else begin
            if (w_tmo_hit) r_err_tmo <= 1'b1;
            if (w_capture) begin
                r_got_word <= 1'b1;
                r_tmo_cnt  <= '0;
            end else if ((r_state == S_WAIT) && dat_blk_done_i) begin
                r_got_word <= 1'b0;
                r_tmo_cnt  <= '0;
            end else if ((r_state == S_WAIT) && !r_got_word && clkstrb_i) begin
                r_tmo_cnt  <= w_tmo_next[TMO_W-1:0];
            end
        end
    end

    assign err_tmo_o = r_err_tmo;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^{clkstrb_i, cfg_tmo_i};
    assign w_tmo_hit    = 1'b0;
    assign err_tmo_o    = 1'b0;
`endif

    assign err_crc_o   = r_err_crc;
    assign err_abort_o = r_err_abort;
    assign blk_cnt_o   = r_blk_cnt;
    assign rx_data_o   = r_rx_data;
    assign rx_valid_o  = r_rx_valid;
    assign dat_d4_o    = cfg_d4_i;
    assign dat_dmode_o = 2'b10;

endmodule
`default_nettype wire

// File: tb/tb_neosd_rd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_neosd_rd_seq
// Brief    : Scoreboard bench for neosd_rd_seq with a behavioural DAT FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neosd_rd_seq;
    localparam int BLK_W = 16;
    localparam int TMO_W = 20;

    logic             clk            = 1'b0;
    logic             rstn_i         = 1'b0;
    logic             clkstrb_i      = 1'b0;
    logic             start_i        = 1'b0;
    logic             abort_i        = 1'b0;
    logic [BLK_W-1:0] cfg_blocks_i   = '0;
    logic             cfg_d4_i       = 1'b0;
    logic [TMO_W-1:0] cfg_tmo_i      = 20'd1000;
    logic             dat_idle_i     = 1'b1;
    logic             dat_data_i     = 1'b0;
    logic             dat_blk_done_i = 1'b0;
    logic             dat_crc_ok_i   = 1'b0;
    logic [31:0]      dat_word_i     = '0;
    logic             rx_ready_i     = 1'b1;
    logic             busy_o, done_o, err_crc_o, err_tmo_o, err_abort_o;
    logic [BLK_W-1:0] blk_cnt_o;
    logic             dat_start_o, dat_ack_o, dat_last_o, dat_d4_o;
    logic [1:0]       dat_dmode_o;
    logic [31:0]      rx_data_o;
    logic             rx_valid_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_done   = 0;
    int          rdy_mode = 0;
    bit          stall_done = 1'b0;
    logic [31:0] exp_q[$];

    neosd_rd_seq #(.BLK_W(BLK_W), .TMO_W(TMO_W)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .clkstrb_i(clkstrb_i), .start_i(start_i),
        .abort_i(abort_i), .cfg_blocks_i(cfg_blocks_i), .cfg_d4_i(cfg_d4_i),
        .cfg_tmo_i(cfg_tmo_i), .busy_o(busy_o), .done_o(done_o),
        .err_crc_o(err_crc_o), .err_tmo_o(err_tmo_o), .err_abort_o(err_abort_o),
        .blk_cnt_o(blk_cnt_o), .dat_start_o(dat_start_o), .dat_ack_o(dat_ack_o),
        .dat_last_o(dat_last_o), .dat_d4_o(dat_d4_o), .dat_dmode_o(dat_dmode_o),
        .dat_idle_i(dat_idle_i), .dat_data_i(dat_data_i),
        .dat_blk_done_i(dat_blk_done_i), .dat_crc_ok_i(dat_crc_ok_i),
        .dat_word_i(dat_word_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle bound", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SD bit strobe: every other clock
    initial forever begin
        tick();
        clkstrb_i = ~clkstrb_i;
    end

    // Scoreboard monitor: a handshake completes at the next posedge
    always @(negedge clk) begin
        if (rstn_i && done_o) n_done++;
        if (rstn_i && rx_valid_o && rx_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got word 0x%0h, expected no word", rx_data_o);
            end else begin
                check("rx_word", {32'h0, rx_data_o}, {32'h0, exp_q.pop_front()});
                n_acc++;
            end
        end
    end

    // Sink readiness: 0 always ready, 1 random, 2 one 50-clock stall after word 5
    initial forever begin
        tick();
        if (rdy_mode == 2 && !stall_done && n_acc == 5) begin
            rx_ready_i = 1'b0;
            repeat (50) @(posedge clk);
            #1;
            check("stall_rx_valid", rx_valid_o, 1);
            check("stall_no_ack", dat_ack_o, 0);
            if (exp_q.size() > 0) check("stall_rx_data", rx_data_o, exp_q[0]);
            rx_ready_i = 1'b1;
            stall_done = 1'b1;
        end else if (rdy_mode == 1) begin
            rx_ready_i = ($urandom_range(3) != 0);
        end else begin
            rx_ready_i = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Behavioural DAT FSM: delivers wpb words per block until the sequencer asks to stop.
    task automatic dat_model(input int nblk, input int wpb, input int bad_blk, input int abort_blk);
        int k;
        k = 0;
        while (!dat_start_o && k < 50) begin tick(); k++; end
        if (!dat_start_o) begin fail_to("dat_start"); return; end
        dat_idle_i = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < wpb; w++) begin
                repeat ($urandom_range(2)) tick();
                dat_word_i = $urandom;
                exp_q.push_back(dat_word_i);
                dat_data_i = 1'b1;
                k = 0;
                do begin tick(); k++; end while (!dat_ack_o && k < 2000);
                if (!dat_ack_o) begin fail_to("dat_ack_rise"); dat_data_i = 1'b0; return; end
                dat_data_i = 1'b0;
                k = 0;
                do begin tick(); k++; end while (dat_ack_o && k < 20);
                if (dat_ack_o) begin fail_to("dat_ack_fall"); return; end
            end
            repeat ($urandom_range(2)) tick();
            dat_crc_ok_i   = (b != bad_blk);
            dat_blk_done_i = 1'b1;
            if (b == abort_blk) abort_i = 1'b1;
            tick();
            dat_blk_done_i = 1'b0;
            dat_crc_ok_i   = 1'b0;
            abort_i        = 1'b0;
            if (dat_last_o) break;
        end
        check("stop_dat_last", dat_last_o, 1);
        repeat (2) tick();
        check("dat_last_held", dat_last_o, 1);
        dat_idle_i = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (busy_o && k < 50) begin tick(); k++; end
        if (busy_o) fail_to("done_wait");
        repeat (3) tick();
        check("done_pulses", n_done - d0, 1);
    endtask

    task automatic run_read(input int blocks, input int wpb, input int bad_blk,
                            input int abort_blk, input int mode);
        int eff, deliv, good, d0, k;
        bit e_crc, e_abort;
        // Reference: the read ends at the first bad, aborted or final block
        eff   = (blocks == 0) ? 1 : blocks;
        deliv = eff;
        if (bad_blk >= 0 && bad_blk < deliv)     deliv = bad_blk + 1;
        if (abort_blk >= 0 && abort_blk < deliv) deliv = abort_blk + 1;
        e_crc   = (bad_blk >= 0 && bad_blk < deliv);
        e_abort = (abort_blk >= 0 && abort_blk < deliv);
        good    = deliv - (e_crc ? 1 : 0);

        rdy_mode   = mode;
        n_acc      = 0;
        stall_done = 1'b0;
        d0         = n_done;
        cfg_blocks_i = blocks[BLK_W-1:0];
        cfg_d4_i     = 1'($urandom_range(1));
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("d4_copy", dat_d4_o, cfg_d4_i);
        dat_model(eff, wpb, bad_blk, abort_blk);
        wait_done(d0);
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin tick(); k++; end
        check("words_left", exp_q.size(), 0);
        check("blk_cnt", blk_cnt_o, good);
        check("err_crc", err_crc_o, e_crc);
        check("err_abort", err_abort_o, e_abort);
        check("err_tmo", err_tmo_o, 0);
        check("idle_after", busy_o, 0);
        rdy_mode = 0;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_dat_ctl"}, {dat_start_o, dat_ack_o, dat_last_o}, 0);
        check({tag, "_errs"}, {err_crc_o, err_tmo_o, err_abort_o}, 0);
        check({tag, "_blk_cnt"}, blk_cnt_o, 0);
        check({tag, "_rx"}, {rx_valid_o, rx_data_o}, 0);
    endtask

    initial begin
        int k, n, d0, r, blocks, bad, abt;
        #2;
        check_all_low("reset");
        check("dmode", dat_dmode_o, 2'b10);
        repeat (2) tick();
        rstn_i = 1'b1;
        repeat (10) tick();
        check("idle_no_start", {busy_o, dat_start_o}, 0);

        run_read(2, 128, -1, -1, 0);
        run_read(3, 8, 1, -1, 0);
        run_read(2, 16, -1, -1, 2);
        check("stall_happened", stall_done, 1);

        // Start bit never arrives
        cfg_tmo_i    = 20'd100;
        cfg_blocks_i = 16'd1;
        d0 = n_done;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        k = 0;
        while (!dat_start_o && k < 50) begin tick(); k++; end
        dat_idle_i = 1'b0;
`ifdef NEOSD_RD_TIMEOUT_EN
        @(posedge clk);
        n = 0;
        k = 0;
        do begin
            @(posedge clk);
            if (clkstrb_i) n++;
            #1;
            k++;
        end while (!dat_last_o && k < 1000);
        check("tmo_strobes", n, 100);
        check("tmo_err_tmo", err_tmo_o, 1);
        check("tmo_err_abort", err_abort_o, 0);
`else
        repeat (300) tick();
        check("notmo_waiting", {busy_o, dat_last_o, err_tmo_o}, 3'b100);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("notmo_abort_stop", dat_last_o, 1);
        check("notmo_err_abort", err_abort_o, 1);
`endif
        repeat (2) tick();
        dat_idle_i = 1'b1;
        wait_done(d0);
        cfg_tmo_i = 20'd1000;

        run_read(3, 6, -1, 1, 0);
        run_read(0, 4, -1, -1, 1);

        // Reset while an ack is in progress
        cfg_blocks_i = 16'd1;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        dat_idle_i = 1'b0;
        dat_word_i = $urandom | 32'h1;
        dat_data_i = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!dat_ack_o && k < 50);
        if (!dat_ack_o) fail_to("capt_ack");
        #2;
        rstn_i = 1'b0;
        #1;
        check_all_low("capt_reset");
        dat_data_i = 1'b0;
        dat_idle_i = 1'b1;
        exp_q.delete();
        tick();
        rstn_i = 1'b1;
        run_read(2, 8, -1, -1, 1);

        for (int i = 0; i < 4; i++) begin
            blocks = $urandom_range(4, 1);
            r      = $urandom_range(blocks + 1);
            bad    = (r >= blocks) ? -1 : r;
            r      = $urandom_range(2 * blocks);
            abt    = (r >= blocks) ? -1 : r;
            run_read(blocks, $urandom_range(6, 1), bad, abt, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/neosd_rd_seq.md
NEOSD_RD_SEQ -- requirements
Module: neosd_rd_seq

Interface
REQ-001 SHALL have parameter BLK_W, default 16, width of block count and block counter.
REQ-002 SHALL have parameter TMO_W, default 20, width of the start-bit timeout counter.
REQ-003 clk_i  in  1  system clock; all state changes on posedge.
REQ-004 rstn_i  in  1  asynchronous, active-low reset.
REQ-005 clkstrb_i  in  1  SD bit strobe shared with the DAT FSM; the timeout counts strobes.
REQ-006 start_i  in  1  one-clk pulse; starts a read of cfg_blocks_i blocks. Ignored unless IDLE.
REQ-007 abort_i  in  1  level; requests early termination.
REQ-008 cfg_blocks_i  in  BLK_W  block count; 0 treated as 1.
REQ-009 cfg_d4_i  in  1  4-bit bus mode; copied to dat_d4_o.
REQ-010 cfg_tmo_i  in  TMO_W  start-bit timeout in strobes.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 done_o  out  1  one-clk pulse when the sequence ends.
REQ-013 err_crc_o, err_tmo_o, err_abort_o  out  1 each  sticky status; cleared on start.
REQ-014 blk_cnt_o  out  BLK_W  blocks completed with good CRC.
REQ-015 dat_start_o, dat_ack_o, dat_last_o, dat_d4_o  out  1 each  drive DAT FSM start, word ack, last-block/abort, bus width.
REQ-016 dat_dmode_o  out  2  constant 2'b10 (read).
REQ-017 dat_idle_i, dat_data_i, dat_blk_done_i, dat_crc_ok_i  in  1 each  DAT FSM status (idle, word ready, block-done strobe, CRC ok).
REQ-018 dat_word_i  in  32  word from the DAT FSM, valid while dat_data_i=1.
REQ-019 rx_data_o  out  32; rx_valid_o  out  1; rx_ready_i  in  1  valid/ready stream of received words.

Function
REQ-020 States: IDLE, START, WAIT, CAPT, ACK, STOP, DONE.
REQ-021 IDLE + start_i: latch block count (0 becomes 1), clear errors and blk_cnt_o, go to START.
REQ-022 START: hold dat_start_o=1 until dat_idle_i=0, then dat_start_o=0 and go to WAIT.
REQ-023 WAIT + dat_data_i=1 + output slot empty: load rx_data_o from dat_word_i, set rx_valid_o, go to CAPT.
REQ-024 CAPT: dat_ack_o=1 held until dat_data_i=0, then dat_ack_o=0 and go to WAIT (the ACK state).
REQ-025 Output slot is one register; rx_valid_o clears on rx_valid_o&rx_ready_i. While the slot is full, no capture occurs and the DAT FSM stalls the SD clock (backpressure).
REQ-026 dat_blk_done_i in WAIT:
  - dat_crc_ok_i=1: increment blk_cnt_o; if it equals the latched count, go to STOP.
  - dat_crc_ok_i=0: set err_crc_o and go to STOP; blk_cnt_o is not incremented.
REQ-027 Timeout: in WAIT, count clkstrb_i while no word has been captured in the current block. Reaching cfg_tmo_i sets err_tmo_o and goes to STOP. The count resets on each capture and on each block-done.
REQ-028 abort_i=1 in START/WAIT/CAPT sets err_abort_o and goes to STOP. In CAPT, the current ack completes first.
REQ-029 STOP: dat_last_o=1 until dat_idle_i=1, then go to DONE.
REQ-030 DONE: done_o=1 for one clk, then IDLE; a pending rx word is kept until it is accepted.
REQ-031 Simultaneous events: abort_i outranks timeout, which outranks dat_blk_done_i. In every case the error flag is still recorded.
REQ-032 blk_cnt_o saturates at all-ones.

Reset
REQ-033 rstn_i low asynchronously forces IDLE and drives every output low: dat_start_o, dat_ack_o, dat_last_o, done_o, busy_o, error flags, blk_cnt_o, rx_valid_o, rx_data_o, counters.
REQ-034 After reset release the block waits in IDLE; no start is issued without start_i.

Configuration
REQ-035 Macro NEOSD_RD_TIMEOUT_EN:
  - Defined: REQ-027 is implemented.
  - Undefined: no timeout counter is built, err_tmo_o is tied 0, and cfg_tmo_i is ignored.

Verification
REQ-036 cfg_blocks=2, d4=0, DAT model returns 2×128 words with CRC ok, rx_ready=1 -> 256 words in order, blk_cnt_o=2, one done_o, no errors.
REQ-037 cfg_blocks=3, second block CRC bad -> blk_cnt_o=1, err_crc_o=1, dat_last_o until idle, done_o.
REQ-038 rx_ready=0 for 50 clks at word 5 -> word 6 is not captured, dat_ack_o stays low, no word is lost or duplicated.
REQ-039 cfg_tmo=100, no start bit (timeout enabled) -> err_tmo_o=1 after 100 strobes, then done_o; with the macro undefined, it waits until abort_i.
REQ-040 abort_i and dat_blk_done_i asserted together mid-transfer -> err_abort_o=1, blk_cnt_o increments if CRC ok, STOP is entered.
REQ-041 rstn_i low during CAPT -> all outputs 0 immediately; a new start_i afterwards gives a normal transfer.
